frame_dram_master: RTL
======================

# frame_dram_master

AXI4 burst master that moves one routing frame (64×64 cells × 4 bits = 2048 bytes = 128 beats of 128 bits) between the on-chip router core and the pseudo DRAM. It is the DUT-side counterpart of the bench's AXI slave. It issues a single INCR read burst to fetch a frame and a single INCR write burst to store it back. It sits between the routing FSM and the chip's `*_s_inf` AXI ports and serialises one transaction at a time.

## Interface
- `ID_WIDTH`, 4, AXI ID width
- `DATA_WIDTH`, 128, AXI data width; fixed at 128 for this block
- `ADDR_WIDTH`, 32, AXI address width
- `FRAME_BASE`, 32'h0001_0000, DRAM address of frame 0
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, synchronous, active-high
- `rd_req` in 1: one-cycle pulse, fetch frame `frame_id`
- `wr_req` in 1: one-cycle pulse, store frame `frame_id`
- `frame_id` in 5: frame index, sampled with the request
- `rd_data` out 128: read beat to core
- `rd_valid` out 1: `rd_data` valid this cycle; no backpressure
- `wr_data` in 128: show-ahead write beat from core
- `wr_pop` out 1: current `wr_data` consumed; core presents next beat the following cycle
- `busy` out 1: transaction in progress
- `done` out 1: one-cycle pulse at transaction end
- `err` out 1: sticky protocol or response error, cleared only by `rst`
- AXI write address: `awid_s_inf` out ID_WIDTH, `awaddr_s_inf` out ADDR_WIDTH, `awsize_s_inf` out 3, `awburst_s_inf` out 2, `awlen_s_inf` out 8, `awvalid_s_inf` out 1, `awready_s_inf` in 1
- AXI write data: `wdata_s_inf` out DATA_WIDTH, `wlast_s_inf` out 1, `wvalid_s_inf` out 1, `wready_s_inf` in 1
- AXI write response: `bid_s_inf` in ID_WIDTH, `bresp_s_inf` in 2, `bvalid_s_inf` in 1, `bready_s_inf` out 1
- AXI read address: `arid_s_inf` out ID_WIDTH, `araddr_s_inf` out ADDR_WIDTH, `arlen_s_inf` out 8, `arsize_s_inf` out 3, `arburst_s_inf` out 2, `arvalid_s_inf` out 1, `arready_s_inf` in 1
- AXI read data: `rid_s_inf` in ID_WIDTH, `rdata_s_inf` in DATA_WIDTH, `rresp_s_inf` in 2, `rlast_s_inf` in 1, `rvalid_s_inf` in 1, `rready_s_inf` out 1

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- Transitions:
  - IDLE→AR on `rd_req`.
  - IDLE→AW on `wr_req`.
  - AR→R on `arvalid&&arready`.
  - R→IDLE on the 128th `rvalid&&rready` beat.
  - AW→W on `awvalid&&awready`.
  - W→B on the 128th `wvalid&&wready` beat.
  - B→IDLE on `bvalid&&bready`.
- Request arbitration:
  - Requests are accepted only in IDLE.
  - If `rd_req` and `wr_req` arrive in the same cycle, read wins and `wr_req` is dropped.
  - Requests while `busy` are ignored.
- Address: `FRAME_BASE + {frame_id, 11'b0}`, latched at acceptance; 32-bit add with no wrap check.
- Constant fields: ID=0, len=8'd127, size=3'b100, burst=2'b01 (INCR).
- Channel control:
  - `arvalid`/`awvalid` are high only in AR/AW and held until handshake.
  - `rready` is high throughout R.
  - `bready` is high throughout B.
  - `wvalid` is high throughout W.
- Write data path:
  - `wdata = wr_data` (combinational).
  - `wr_pop = wvalid&&wready`.
- Beat counter: 7 bits. `wlast` is asserted when the count is 127. The counter clears on entry to R/W.
- Read data path: `rd_data`/`rd_valid` are registered copies of `rdata`/`rvalid&&rready`.
- `err` sets on any of:
  - `rresp` ≠ 0 on a read beat;
  - `rid` ≠ 0;
  - `rlast` asserted on a beat other than the 128th, or missing on the 128th;
  - `bresp` ≠ 0;
  - `bid` ≠ 0.
- Error handling: the transaction still completes on the beat count, and `done` still pulses.

## Timing
- Reset values: all outputs 0 except the constant AXI fields (size, burst, len, ID). FSM→IDLE, counter 0, `err` 0.
- `rst` mid-transaction:
  - The FSM aborts to IDLE next edge and all valids drop.
  - The slave is not drained; the bench resets the DRAM model together with the block.
- Request to address valid: a request at edge t → `arvalid`/`awvalid` high and `busy` high after edge t.
- Read return: beat k handshake at edge t → `rd_valid` with beat k after edge t.
- End of transaction: `done` pulses the cycle after the final R-beat or B handshake. `busy` falls in the same cycle that `done` rises.
- Earliest next request: the cycle `done` is high; it is accepted since the FSM is in IDLE.
- Throughput: one beat per cycle when the slave holds ready/valid high. Minimum read = 1 (AR) + 128 cycles.

## Test plan
- Reset, then `rd_req`, `frame_id`=3 → `araddr`=0x0001_1800, `arlen`=127, `arsize`=4, `arburst`=1. 128 `rd_valid` beats match DRAM contents in order. `done` pulses once, `err`=0.
- `wr_req`, `frame_id`=31, core supplies an incrementing pattern → `awaddr`=0x0001_F800. `wlast` only on beat 128. 128 `wr_pop` pulses. `done` after `bvalid`. Read-back of frame 31 equals the pattern.
- Slave inserts random `arready`/`rvalid`/`wready`/`bvalid` stalls (0–5 cycles) → data identical to the no-stall run. No beat dropped or duplicated. `awvalid`/`wvalid` stable until handshake.
- `rd_req` and `wr_req` in the same cycle, then `wr_req` while busy → only the read executes. Both write requests are ignored. `awvalid` is never asserted.
- Slave returns `rresp`=2 on beat 10 and `rlast` on beat 127 → `err`=1 sticky. Transaction still ends after 128 beats with `done`. `err` clears only after `rst`.
- `rst` asserted during beat 60 of a write → next cycle `wvalid`=0, `busy`=0, `done`=0. A subsequent `rd_req` proceeds normally.

Source files
------------

// File: rtl/frame_dram_master.sv
// ============================================================================
// frame_dram_master
// AXI4 burst master that moves one 2048-byte routing frame (128 beats of
// 128 bits) between the router core and DRAM. Each frame is moved with one
// INCR read burst or one INCR write burst. Only one transaction runs at a time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_dram_master #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] FRAME_BASE = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  // core side
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [4:0]            frame_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pop,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  // AXI write address
  output logic [ID_WIDTH-1:0]   awid_s_inf,
  output logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  output logic [2:0]            awsize_s_inf,
  output logic [1:0]            awburst_s_inf,
  output logic [7:0]            awlen_s_inf,
  output logic                  awvalid_s_inf,
  input  logic                  awready_s_inf,
  // AXI write data
  output logic [DATA_WIDTH-1:0] wdata_s_inf,
  output logic                  wlast_s_inf,
  output logic                  wvalid_s_inf,
  input  logic                  wready_s_inf,
  // AXI write response
  input  logic [ID_WIDTH-1:0]   bid_s_inf,
  input  logic [1:0]            bresp_s_inf,
  input  logic                  bvalid_s_inf,
  output logic                  bready_s_inf,
  // AXI read address
  output logic [ID_WIDTH-1:0]   arid_s_inf,
  output logic [ADDR_WIDTH-1:0] araddr_s_inf,
  output logic [7:0]            arlen_s_inf,
  output logic [2:0]            arsize_s_inf,
  output logic [1:0]            arburst_s_inf,
  output logic                  arvalid_s_inf,
  input  logic                  arready_s_inf,
  // AXI read data
  input  logic [ID_WIDTH-1:0]   rid_s_inf,
  input  logic [DATA_WIDTH-1:0] rdata_s_inf,
  input  logic [1:0]            rresp_s_inf,
  input  logic                  rlast_s_inf,
  input  logic                  rvalid_s_inf,
  output logic                  rready_s_inf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5
  } state_t;

  localparam logic [6:0] LAST_BEAT = 7'd127;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [6:0]            beat_cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  ar_hs;
  logic                  aw_hs;
  logic                  rd_hs;
  logic                  wr_hs;
  logic                  b_hs;
  logic                  last_beat;
  logic                  rd_beat_bad;
  logic                  b_bad;

  // Frames are 2 KiB apart; the add is a plain 32-bit add without wrap check.
  assign req_addr  = ADDR_WIDTH'(FRAME_BASE) + ADDR_WIDTH'({frame_id, 11'b0});

  assign ar_hs     = arvalid_s_inf && arready_s_inf;
  assign aw_hs     = awvalid_s_inf && awready_s_inf;
  assign rd_hs     = rvalid_s_inf && rready_s_inf;
  assign wr_hs     = wvalid_s_inf && wready_s_inf;
  assign b_hs      = bvalid_s_inf && bready_s_inf;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // A read beat is faulty on a bad response, a non-zero ID, or rlast that
  // does not line up with the 128th beat.
  assign rd_beat_bad = (rresp_s_inf != 2'b00) || (rid_s_inf != '0) ||
                       (rlast_s_inf != last_beat);
  assign b_bad       = (bresp_s_inf != 2'b00) || (bid_s_inf != '0);

  // Fixed burst shape: 128 beats of 16 bytes, INCR, ID 0.
  assign arid_s_inf    = '0;
  assign arlen_s_inf   = 8'd127;
  assign arsize_s_inf  = 3'b100;
  assign arburst_s_inf = 2'b01;
  assign awid_s_inf    = '0;
  assign awlen_s_inf   = 8'd127;
  assign awsize_s_inf  = 3'b100;
  assign awburst_s_inf = 2'b01;
  assign araddr_s_inf  = addr;
  assign awaddr_s_inf  = addr;

  // Write beats flow straight from the core's show-ahead output.
  assign wdata_s_inf = wr_data;
  assign wlast_s_inf = wvalid_s_inf && last_beat;
  assign wr_pop      = wr_hs;

  // Transaction FSM with registered channel controls and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      beat_cnt      <= '0;
      arvalid_s_inf <= 1'b0;
      awvalid_s_inf <= 1'b0;
      rready_s_inf  <= 1'b0;
      wvalid_s_inf  <= 1'b0;
      bready_s_inf  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Read wins a simultaneous request; the write request is dropped.
          if (rd_req) begin
            state         <= S_AR;
            arvalid_s_inf <= 1'b1;
            busy          <= 1'b1;
            addr          <= req_addr;
          end else if (wr_req) begin
            state         <= S_AW;
            awvalid_s_inf <= 1'b1;
            busy          <= 1'b1;
            addr          <= req_addr;
          end
        end
        S_AR: begin
          if (ar_hs) begin
            state         <= S_R;
            arvalid_s_inf <= 1'b0;
            rready_s_inf  <= 1'b1;
            beat_cnt      <= '0;
          end
        end
        S_R: begin
          if (rd_hs) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (rd_beat_bad) begin
              err <= 1'b1;
            end
            // Completion follows the beat count, not rlast.
            if (last_beat) begin
              state        <= S_IDLE;
              rready_s_inf <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        S_AW: begin
          if (aw_hs) begin
            state         <= S_W;
            awvalid_s_inf <= 1'b0;
            wvalid_s_inf  <= 1'b1;
            beat_cnt      <= '0;
          end
        end
        S_W: begin
          if (wr_hs) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (last_beat) begin
              state        <= S_B;
              wvalid_s_inf <= 1'b0;
              bready_s_inf <= 1'b1;
            end
          end
        end
        S_B: begin
          if (b_hs) begin
            if (b_bad) begin
              err <= 1'b1;
            end
            state        <= S_IDLE;
            bready_s_inf <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Read beats are forwarded to the core one cycle after their handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_hs;
      rd_data  <= rdata_s_inf;
    end
  end

endmodule

`default_nettype wire
